bp_fe_ram64x7_ctrl: RTL and testbench

Request/response controller sitting directly upstream of the 64x7 front-end SRAM macro; it drives the macro's ce/we/addr/wd/mask pins and consumes its rd_out.
Converts a valid/ready request stream into single-cycle macro accesses, tracks the macro's 1-cycle read latency, and buffers read data so downstream backpressure never loses data.
Optionally zero-fills the array after reset before accepting traffic.

---
 rtl/bp_fe_ram_ctrl_pkg.sv | 17 +
 rtl/bp_fe_ram_resp_fifo.sv | 54 +++++
 rtl/bp_fe_ram64x7_ctrl.sv | 124 ++++++++++++
 tb/tb_bp_fe_ram64x7_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/bp_fe_ram_ctrl_pkg.sv
// Shared types and default sizes for the 64x7 front-end SRAM controller.
package bp_fe_ram_ctrl_pkg;

    localparam int unsigned DEFAULT_BITS       = 7;
    localparam int unsigned DEFAULT_ADDR_WIDTH = 6;
    localparam int unsigned DEFAULT_WORD_DEPTH = 64;

    // INIT zero-fills the array; RUN serves requests.
    typedef enum logic {
        INIT,
        RUN
    } state_e;

    // Walks every entry once during the zero-fill sweep.
    typedef logic [DEFAULT_ADDR_WIDTH-1:0] sweep_addr_t;

endpackage

// File: rtl/bp_fe_ram_resp_fifo.sv
// Small synchronous FIFO that holds read data until the consumer takes it.
module bp_fe_ram_resp_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 7,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Pointers and occupancy; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; occupancy decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/bp_fe_ram64x7_ctrl.sv
// Valid/ready front end for the 64x7 SRAM macro with credit-limited read buffering.
// Define BP_FE_RAM_CTRL_INIT_EN to zero-fill the array after reset before accepting requests.
module bp_fe_ram64x7_ctrl
    import bp_fe_ram_ctrl_pkg::*;
#(
    parameter int unsigned BITS       = DEFAULT_BITS,
    parameter int unsigned WORD_DEPTH = DEFAULT_WORD_DEPTH,
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int unsigned RESP_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_v,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [BITS-1:0]       req_wdata,
    input  logic [BITS-1:0]       req_wmask,
    output logic                  resp_v,
    input  logic                  resp_ready,
    output logic [BITS-1:0]       resp_data,
    output logic                  mem_ce,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [BITS-1:0]       mem_wd,
    output logic [BITS-1:0]       mem_wmask,
    input  logic [BITS-1:0]       mem_rd
);

    localparam int unsigned CNT_W = $clog2(RESP_DEPTH + 1);

    state_e           state_q;
    logic             rd_pend_q;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty, fifo_full;
    logic             fire, pop, credit_ok;
    int unsigned      occ;

`ifdef BP_FE_RAM_CTRL_INIT_EN
    state_e      state_d;
    sweep_addr_t sweep_q, sweep_d;

    // State and sweep counter registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= INIT;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    // Sweep advances every INIT cycle; leave after writing the last entry.
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        if (state_q == INIT) begin
            sweep_d = sweep_q + 1'b1;
            if (sweep_q == sweep_addr_t'(WORD_DEPTH - 1)) state_d = RUN;
        end
    end
`else
    assign state_q = RUN;
`endif

    // A buffer slot is reserved at fire time, so an in-flight read counts as occupied.
    always_comb begin
        occ       = 32'(fifo_count) + 32'(rd_pend_q);
        credit_ok = (occ - 32'(pop)) < RESP_DEPTH;
    end

    assign resp_v    = reset_n && !fifo_empty;
    assign pop       = resp_v && resp_ready;
    assign req_ready = reset_n && (state_q == RUN) && credit_ok;
    assign fire      = req_v && req_ready;

    // Macro pin drive: sweep writes in INIT, request pass-through in RUN.
    always_comb begin
        mem_ce    = fire;
        mem_we    = fire && req_we;
        mem_addr  = req_addr;
        mem_wd    = req_wdata;
        mem_wmask = req_wmask;
`ifdef BP_FE_RAM_CTRL_INIT_EN
        if (state_q == INIT) begin
            mem_ce    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = sweep_q;
            mem_wd    = '0;
            mem_wmask = '1;
        end
`endif
        mem_ce = mem_ce && reset_n;
        mem_we = mem_we && reset_n;
    end

    // Macro read data is valid the cycle after a read fire.
    always_ff @(posedge clk) begin
        if (!reset_n) rd_pend_q <= 1'b0;
        else          rd_pend_q <= fire && !req_we;
    end

    bp_fe_ram_resp_fifo #(
        .DEPTH (RESP_DEPTH),
        .WIDTH (BITS)
    ) u_resp_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (rd_pend_q),
        .push_data (mem_rd),
        .pop       (pop),
        .pop_data  (resp_data),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(rd_pend_q && fifo_full && !pop));
`endif

endmodule

// File: tb/tb_bp_fe_ram64x7_ctrl.sv
// Bench for bp_fe_ram64x7_ctrl: behavioural SRAM macro plus a transaction-level reference model.
module tb_bp_fe_ram64x7_ctrl;

`ifdef BP_FE_RAM_CTRL_INIT_EN
    localparam int INIT_CYCLES = 64;
`else
    localparam int INIT_CYCLES = 0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       req_v, req_ready, req_we;
    logic [5:0] req_addr;
    logic [6:0] req_wdata, req_wmask;
    logic       resp_v, resp_ready;
    logic [6:0] resp_data;
    logic       mem_ce, mem_we;
    logic [5:0] mem_addr;
    logic [6:0] mem_wd, mem_wmask, mem_rd;

    always #5 clk = ~clk;

    bp_fe_ram64x7_ctrl #(
        .BITS       (7),
        .WORD_DEPTH (64),
        .ADDR_WIDTH (6),
        .RESP_DEPTH (2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_v      (req_v),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wmask  (req_wmask),
        .resp_v     (resp_v),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .mem_ce     (mem_ce),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wd     (mem_wd),
        .mem_wmask  (mem_wmask),
        .mem_rd     (mem_rd)
    );

    // Macro model: masked write, or registered read with 1-cycle latency.
    logic [6:0] macro_mem [64] = '{default: '0};
    always @(posedge clk) begin
        if (mem_ce) begin
            if (mem_we) macro_mem[mem_addr] <= (macro_mem[mem_addr] & ~mem_wmask) | (mem_wd & mem_wmask);
            else        mem_rd <= macro_mem[mem_addr];
        end
    end

    // Reference: array contents plus a queue of expected responses tagged with fire cycle.
    typedef struct packed {
        logic [6:0]  data;
        logic [31:0] fc;
    } resp_t;

    logic [6:0] ref_mem [64] = '{default: '0};
    resp_t      exp_q [$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    int         sweep_cnt = 0;
    bit         fd;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // One clock: check outputs against the model, then advance the model at the edge.
    task automatic step(output bit fired);
        bit in_init, in_run, head_ok, rv_e, pop_e, ready_e, fire_e;
        int a;
        #1;
        in_init = reset_n && (sweep_cnt < INIT_CYCLES);
        in_run  = reset_n && (sweep_cnt >= INIT_CYCLES);
        head_ok = (exp_q.size() > 0) && (int'(exp_q[0].fc) + 2 <= cyc);
        rv_e    = reset_n && head_ok;
        pop_e   = rv_e && resp_ready;
        ready_e = in_run && ((exp_q.size() - int'(pop_e)) < 2);
        fire_e  = req_v && ready_e;
        fired   = req_v && req_ready;

        check_eq("resp_v", 32'(resp_v), 32'(rv_e));
        if (rv_e) check_eq("resp_data", 32'(resp_data), 32'(exp_q[0].data));
        check_eq("req_ready", 32'(req_ready), 32'(ready_e));
        check_eq("mem_ce", 32'(mem_ce), 32'(in_init || fire_e));
        if (in_init) begin
            check_eq("sweep_we", 32'(mem_we), 32'd1);
            check_eq("sweep_addr", 32'(mem_addr), 32'(sweep_cnt));
            check_eq("sweep_wd", 32'(mem_wd), 32'd0);
            check_eq("sweep_mask", 32'(mem_wmask), 32'h7f);
        end else if (fire_e) begin
            check_eq("mem_we", 32'(mem_we), 32'(req_we));
            check_eq("mem_addr", 32'(mem_addr), 32'(req_addr));
            if (req_we) begin
                check_eq("mem_wd", 32'(mem_wd), 32'(req_wdata));
                check_eq("mem_wmask", 32'(mem_wmask), 32'(req_wmask));
            end
        end else begin
            check_eq("mem_we_idle", 32'(mem_we), 32'd0);
        end

        @(posedge clk);
        if (!reset_n) begin
            exp_q.delete();
            sweep_cnt = 0;
        end else begin
            if (in_init) begin
                ref_mem[sweep_cnt] = '0;
                sweep_cnt++;
            end
            if (pop_e) void'(exp_q.pop_front());
            if (fire_e) begin
                a = int'(req_addr);
                if (req_we) ref_mem[a] = (ref_mem[a] & ~req_wmask) | (req_wdata & req_wmask);
                else        exp_q.push_back('{data: ref_mem[a], fc: 32'(cyc)});
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bit f;
        req_v = 1'b0;
        repeat (n) step(f);
    endtask

    // Hold a request until accepted, bounded so a stuck req_ready cannot hang the run.
    task automatic issue(input bit we, input logic [5:0] a, input logic [6:0] d, input logic [6:0] m);
        bit done = 1'b0;
        int waits = 0;
        req_v = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_wmask = m;
        while (!done && waits < 20) begin
            step(done);
            waits++;
        end
        req_v = 1'b0;
        if (!done) check_eq("issue_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        reset_n = 1'b0; req_v = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; req_wmask = '0; resp_ready = 1'b1;
        @(negedge clk);
        repeat (3) step(fd);

        // Sweep interrupted at address 30, then a full restart from 0.
        reset_n = 1'b1;
        repeat (30) step(fd);
        reset_n = 1'b0;
        step(fd);
        reset_n = 1'b1;
        repeat (66) step(fd);

        // Zero-filled read, write-then-read, masked merge.
        issue(1'b0, 6'd17, 7'h00, 7'h00);
        idle(3);
        issue(1'b1, 6'd5, 7'h55, 7'h7f);
        issue(1'b0, 6'd5, 7'h00, 7'h00);
        issue(1'b1, 6'd5, 7'h2a, 7'h0f);
        issue(1'b0, 6'd5, 7'h00, 7'h00);
        idle(4);

        // Back-to-back reads with the consumer always ready.
        for (int i = 0; i < 8; i++) issue(1'b0, 6'(i), 7'h00, 7'h00);
        idle(4);

        // Backpressure: credits run out, then one pop admits one request in the same cycle.
        resp_ready = 1'b0;
        req_v = 1'b1; req_we = 1'b0; req_addr = 6'd9;
        repeat (4) step(fd);
        resp_ready = 1'b1;
        step(fd);
        resp_ready = 1'b0;
        repeat (3) step(fd);
        resp_ready = 1'b1;
        idle(5);

        // Reset with a response buffered: it must be discarded.
        resp_ready = 1'b0;
        issue(1'b0, 6'd3, 7'h00, 7'h00);
        idle(3);
        reset_n = 1'b0;
        step(fd);
        reset_n = 1'b1;
        resp_ready = 1'b1;
        idle(70);

        // Randomized traffic over a small address window to provoke read-after-write.
        repeat (400) begin
            req_v      = 1'($urandom_range(0, 1));
            req_we     = 1'($urandom_range(0, 1));
            req_addr   = 6'($urandom_range(0, 7));
            req_wdata  = 7'($urandom);
            req_wmask  = 7'($urandom);
            resp_ready = ($urandom_range(0, 3) != 0);
            step(fd);
        end
        resp_ready = 1'b1;
        idle(6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
